// File: rtl/registers_file.sv
// General-purpose register file for the MIPS multicycle datapath.
// 2^ADDR_WIDTH x DATA_WIDTH storage, two combinational read ports, one
// synchronous write port. Register 0 always reads zero.
module registers_file #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned ADDR_WIDTH = 5
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [ADDR_WIDTH-1:0] src1,
   input  logic [ADDR_WIDTH-1:0] src2,
   input  logic [ADDR_WIDTH-1:0] dest,
   input  logic [DATA_WIDTH-1:0] write_value,
   input  logic                  write_en,
   output logic [DATA_WIDTH-1:0] out1,
   output logic [DATA_WIDTH-1:0] out2
);

   localparam int unsigned NumRegs = 1 << ADDR_WIDTH;

   logic [DATA_WIDTH-1:0] regs_q [NumRegs];
   logic                  wr_active;

   // Writes to register 0 are dropped here so its storage is only ever cleared.
   always_comb begin
      wr_active = write_en && (dest != '0);
   end

   // Storage update: reset clears every entry and overrides any pending write.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NumRegs; i++) begin
            regs_q[i] <= '0;
         end
      end else if (wr_active) begin
         regs_q[dest] <= write_value;
      end
   end

   // Read ports: no bypass, so a same-cycle write is visible only after the edge.
   // Index 0 is forced to zero so it reads 0 even before the first reset.
   always_comb begin
      out1 = '0;
      out2 = '0;
      if (src1 != '0) out1 = regs_q[src1];
      if (src2 != '0) out2 = regs_q[src2];
   end

endmodule

// File: tb/tb_registers_file.sv
// Self-checking bench for registers_file: directed vector table, a hand-written
// read-before/after-write sequence, then randomized traffic against an array model.
module tb_registers_file;

   localparam int unsigned DW = 32;
   localparam int unsigned AW = 5;
   localparam int unsigned NR = 1 << AW;

   logic          clk = 1'b0;
   logic          rst;
   logic [AW-1:0] src1, src2, dest;
   logic [DW-1:0] write_value;
   logic          write_en;
   logic [DW-1:0] out1, out2;

   int checks = 0;
   int passed = 0;

   logic [DW-1:0] mdl [NR];

   registers_file #(
      .DATA_WIDTH(DW),
      .ADDR_WIDTH(AW)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .src1       (src1),
      .src2       (src2),
      .dest       (dest),
      .write_value(write_value),
      .write_en   (write_en),
      .out1       (out1),
      .out2       (out2)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic          rst;
      logic          we;
      logic [AW-1:0] dest;
      logic [DW-1:0] wval;
      logic [AW-1:0] s1;
      logic [AW-1:0] s2;
      logic [DW-1:0] e1;
      logic [DW-1:0] e2;
   } vec_t;

   task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      checks++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   // Advance past the next rising edge so outputs are sampled away from it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [DW-1:0] mread(input logic [AW-1:0] a);
      return (a == 0) ? '0 : mdl[a];
   endfunction

   vec_t vecs [8];

   initial begin
      rst = 1'b0; write_en = 1'b0; dest = '0; write_value = '0; src1 = '0; src2 = '0;

      vecs[0] = '{1'b1, 1'b0, 5'd0,  32'd0,         5'd7,  5'd31, 32'd0,         32'd0};
      vecs[1] = '{1'b0, 1'b1, 5'd0,  32'd5,         5'd0,  5'd0,  32'd0,         32'd0};
      vecs[2] = '{1'b0, 1'b1, 5'd1,  32'd5,         5'd1,  5'd1,  32'd5,         32'd5};
      vecs[3] = '{1'b0, 1'b1, 5'd20, 32'd25,        5'd20, 5'd30, 32'd25,        32'd0};
      vecs[4] = '{1'b0, 1'b0, 5'd20, 32'd99,        5'd20, 5'd1,  32'd25,        32'd5};
      vecs[5] = '{1'b0, 1'b1, 5'd31, 32'hFFFF_FFFF, 5'd31, 5'd0,  32'hFFFF_FFFF, 32'd0};
      vecs[6] = '{1'b1, 1'b1, 5'd3,  32'd7,         5'd3,  5'd20, 32'd0,         32'd0};
      vecs[7] = '{1'b0, 1'b0, 5'd0,  32'd0,         5'd1,  5'd31, 32'd0,         32'd0};

      @(posedge clk); #1;

      // Directed table: apply write-side inputs, clock, then read back.
      for (int i = 0; i < 8; i++) begin
         rst = vecs[i].rst; write_en = vecs[i].we; dest = vecs[i].dest;
         write_value = vecs[i].wval;
         tick();
         rst = 1'b0; write_en = 1'b0;
         src1 = vecs[i].s1; src2 = vecs[i].s2;
         #1;
         chk($sformatf("vec%0d_out1", i), out1, vecs[i].e1);
         chk($sformatf("vec%0d_out2", i), out2, vecs[i].e2);
      end

      // Read-before/after: write to 20 is invisible until the edge, then appears.
      src1 = 5'd20; src2 = 5'd30;
      #1;
      chk("rba_initial_out1", out1, 32'd0);
      write_en = 1'b1; dest = 5'd20; write_value = 32'd25;
      #1;
      chk("rba_before_edge_out1", out1, 32'd0);
      chk("rba_before_edge_out2", out2, 32'd0);
      tick();
      chk("rba_after_edge_out1", out1, 32'd25);
      chk("rba_after_edge_out2", out2, 32'd0);
      write_en = 1'b0;

      // Both ports on the same register.
      src1 = 5'd20; src2 = 5'd20;
      #1;
      chk("same_reg_out1", out1, 32'd25);
      chk("same_reg_out2", out2, 32'd25);

      // Randomized traffic against the array model; start from a clean reset.
      rst = 1'b1;
      tick();
      rst = 1'b0;
      for (int i = 0; i < NR; i++) mdl[i] = '0;
      for (int n = 0; n < 300; n++) begin
         rst         = ($urandom_range(39) == 0);
         write_en    = $urandom_range(1);
         dest        = AW'($urandom_range(NR - 1));
         write_value = $urandom;
         src1        = ($urandom_range(3) == 0) ? dest : AW'($urandom_range(NR - 1));
         src2        = AW'($urandom_range(NR - 1));
         #1;
         chk($sformatf("rnd%0d_pre_out1", n), out1, mread(src1));
         chk($sformatf("rnd%0d_pre_out2", n), out2, mread(src2));
         tick();
         if (rst) begin
            for (int i = 0; i < NR; i++) mdl[i] = '0;
         end else if (write_en && dest != 0) begin
            mdl[dest] = write_value;
         end
         chk($sformatf("rnd%0d_post_out1", n), out1, mread(src1));
         chk($sformatf("rnd%0d_post_out2", n), out2, mread(src2));
      end

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
